// File: rtl/store_rmw_sequencer.sv
// Store sequencer in front of the store-size merge stage: reads the target word for
// byte/halfword stores, holds it in the memory-data register, then issues one write.
module store_rmw_sequencer #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        size_ctrl,
    input  logic [ADDR_W-1:0] addr_in,
    input  logic [31:0]       mem_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [31:0]       mdr_out,
    output logic [1:0]        store_size_out,
    output logic              busy,
    output logic              done,
    output logic              size_err
);

    // The read counter is only four bits wide, so the latency must fit in 1..15.
    if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
        $error("store_rmw_sequencer: MEM_LATENCY must be in 1..15");
    end

    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            state_reg;
    state_t            state_next;
    logic [3:0]        cnt_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       mdr_reg;
    logic [1:0]        size_reg;
    logic              size_err_reg;

    logic accept_sub;
    logic accept_word;
    logic reject;

    assign accept_sub  = (state_reg == S_IDLE) && start && !size_ctrl[1];
    assign accept_word = (state_reg == S_IDLE) && start && (size_ctrl == 2'b10);
    assign reject      = (state_reg == S_IDLE) && start && (size_ctrl == 2'b11);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (accept_sub) begin
                    state_next = S_RD_WAIT;
                end else if (accept_word) begin
                    state_next = S_WRITE;
                end
            end
            S_RD_WAIT: begin
                if (cnt_reg == 4'd1) begin
                    state_next = S_WRITE;
                end
            end
            S_WRITE: state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Latched address/size/data only change on an accepted start or the final read edge,
    // so the merge stage sees stable inputs from WRITE until the next accepted store.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg      <= 4'd0;
            addr_reg     <= '0;
            mdr_reg      <= 32'd0;
            size_reg     <= 2'b00;
            size_err_reg <= 1'b0;
        end else begin
            size_err_reg <= reject;
            if (accept_sub || accept_word) begin
                addr_reg <= addr_in;
                size_reg <= size_ctrl;
            end
            if (accept_sub) begin
                cnt_reg <= CNT_INIT;
            end else if (state_reg == S_RD_WAIT) begin
                cnt_reg <= cnt_reg - 4'd1;
            end
            if (state_reg == S_RD_WAIT && cnt_reg == 4'd1) begin
                mdr_reg <= mem_rdata;
            end
        end
    end

    always_comb begin
        busy   = (state_reg != S_IDLE);
        mem_wr = (state_reg == S_WRITE);
        done   = (state_reg == S_DONE);
    end

    assign mem_addr       = addr_reg;
    assign mdr_out        = mdr_reg;
    assign store_size_out = size_reg;
    assign size_err       = size_err_reg;

endmodule

// File: tb/tb_store_rmw_sequencer.sv
// Bench for store_rmw_sequencer: two instances (read latency 1 and 3) driven by directed
// and random stores, checked cycle by cycle against a word-level memory/merge model.
module tb_store_rmw_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [2];
    logic        start    [2];
    logic [1:0]  sz       [2];
    logic [31:0] addr     [2];
    logic [31:0] rdata    [2];
    logic [31:0] maddr    [2];
    logic        mwr      [2];
    logic [31:0] mdr      [2];
    logic [1:0]  ssz      [2];
    logic        busy     [2];
    logic        done     [2];
    logic        serr     [2];

    store_rmw_sequencer #(.MEM_LATENCY(1), .ADDR_W(32)) u_lat1 (
        .clk(clk), .reset(rst[0]), .start(start[0]), .size_ctrl(sz[0]),
        .addr_in(addr[0]), .mem_rdata(rdata[0]), .mem_addr(maddr[0]), .mem_wr(mwr[0]),
        .mdr_out(mdr[0]), .store_size_out(ssz[0]), .busy(busy[0]), .done(done[0]),
        .size_err(serr[0])
    );

    store_rmw_sequencer #(.MEM_LATENCY(3), .ADDR_W(32)) u_lat3 (
        .clk(clk), .reset(rst[1]), .start(start[1]), .size_ctrl(sz[1]),
        .addr_in(addr[1]), .mem_rdata(rdata[1]), .mem_addr(maddr[1]), .mem_wr(mwr[1]),
        .mdr_out(mdr[1]), .store_size_out(ssz[1]), .busy(busy[1]), .done(done[1]),
        .size_err(serr[1])
    );

    int npass  = 0;
    int ntotal = 0;
    int lat [2];

    // Reference state: memory contents plus the values each instance should be holding.
    logic [31:0] mem [logic [63:0]];
    logic [31:0] m_mdr  [2];
    logic [31:0] m_addr [2];
    logic [1:0]  m_size [2];
    logic [31:0] merge_b;
    logic [31:0] last_written;

    function automatic logic [63:0] mkey(int d, logic [31:0] a);
        return {32'(d), a};
    endfunction

    function automatic logic [31:0] mem_rd(int d, logic [31:0] a);
        if (mem.exists(mkey(d, a))) return mem[mkey(d, a)];
        return a ^ 32'h5A5A_0F0F ^ 32'(d);
    endfunction

    function automatic logic [31:0] ref_merge(logic [31:0] old, logic [31:0] b, logic [1:0] s);
        case (s)
            2'b00:   return {old[31:8], b[7:0]};
            2'b01:   return {old[31:16], b[15:0]};
            default: return b;
        endcase
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called 1 time unit after an edge with the instance idle; returns the same way.
    task automatic store(int d, logic [1:0] s, logic [31:0] a, bit noise);
        logic [31:0] old;
        logic [31:0] expw;
        logic [31:0] expmdr;
        int wc;
        int dc;
        start[d] = 1'b1;
        sz[d]    = s;
        addr[d]  = a;
        rdata[d] = $urandom;
        tick();
        start[d] = 1'b0;
        sz[d]    = 2'($urandom);
        addr[d]  = $urandom;
        if (s == 2'b11) begin
            @(negedge clk);
            chk("illegal_size_err", serr[d], 1'b1);
            chk("illegal_busy", busy[d], 1'b0);
            chk("illegal_mem_wr", mwr[d], 1'b0);
            chk("illegal_addr_held", maddr[d], m_addr[d]);
            chk("illegal_size_held", ssz[d], m_size[d]);
            tick();
            @(negedge clk);
            chk("illegal_err_pulse", serr[d], 1'b0);
            chk("illegal_busy2", busy[d], 1'b0);
            tick();
            $display("d%0d lat=%0d illegal store addr=%h -> rejected", d, lat[d], a);
            return;
        end
        old    = mem_rd(d, a);
        wc     = s[1] ? 1 : lat[d] + 1;
        dc     = wc + 1;
        expmdr = s[1] ? m_mdr[d] : old;
        expw   = ref_merge(old, merge_b, s);
        for (int k = 1; k <= dc + 1; k++) begin
            if (!s[1] && k == lat[d]) rdata[d] = old;
            else rdata[d] = $urandom;
            if (noise && k <= dc) begin
                start[d] = (k == dc) ? 1'b1 : 1'($urandom_range(0, 1));
                sz[d]    = 2'($urandom);
            end else begin
                start[d] = 1'b0;
            end
            @(negedge clk);
            chk("busy", busy[d], 1'(k <= dc));
            chk("mem_wr", mwr[d], 1'(k == wc));
            chk("done", done[d], 1'(k == dc));
            chk("size_err_quiet", serr[d], 1'b0);
            if (k == wc) begin
                chk("wr_addr", maddr[d], a);
                chk("wr_size", ssz[d], s);
                chk("wr_mdr", mdr[d], expmdr);
                last_written = ref_merge(mdr[d], merge_b, ssz[d]);
                chk("wr_word", last_written, expw);
                mem[mkey(d, a)] = expw;
                m_mdr[d]  = expmdr;
                m_addr[d] = a;
                m_size[d] = s;
            end
            if (k == dc) begin
                chk("done_mdr_stable", mdr[d], expmdr);
                chk("done_addr_stable", maddr[d], a);
            end
            tick();
        end
        start[d] = 1'b0;
        $display("d%0d lat=%0d store size=%0d addr=%h old=%h b=%h wrote=%h",
                 d, lat[d], s, a, old, merge_b, last_written);
    endtask

    task automatic reset_mid(int d, logic [31:0] a);
        start[d] = 1'b1;
        sz[d]    = 2'b00;
        addr[d]  = a;
        rdata[d] = mem_rd(d, a);
        tick();
        start[d] = 1'b0;
        rst[d]   = 1'b1;
        tick();
        rst[d]   = 1'b0;
        @(negedge clk);
        chk("rst_busy", busy[d], 1'b0);
        chk("rst_mem_wr", mwr[d], 1'b0);
        chk("rst_mdr", mdr[d], 32'd0);
        chk("rst_addr", maddr[d], 32'd0);
        chk("rst_size", ssz[d], 2'b00);
        chk("rst_done", done[d], 1'b0);
        m_mdr[d]  = 32'd0;
        m_addr[d] = 32'd0;
        m_size[d] = 2'b00;
        for (int k = 0; k < lat[d] + 2; k++) begin
            tick();
            @(negedge clk);
            chk("rst_no_write", mwr[d], 1'b0);
        end
        tick();
        $display("d%0d lat=%0d reset during store addr=%h -> idle, no write", d, lat[d], a);
    endtask

    initial begin
        lat[0] = 1;
        lat[1] = 3;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; start[d] = 1'b0; sz[d] = 2'b00;
            addr[d] = 32'd0; rdata[d] = 32'd0;
            m_mdr[d] = 32'd0; m_addr[d] = 32'd0; m_size[d] = 2'b00;
        end
        tick();
        tick();
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_busy", busy[d], 1'b0);
            chk("reset_mem_wr", mwr[d], 1'b0);
            chk("reset_done", done[d], 1'b0);
            chk("reset_size_err", serr[d], 1'b0);
            chk("reset_mdr", mdr[d], 32'd0);
            chk("reset_addr", maddr[d], 32'd0);
            chk("reset_size", ssz[d], 2'b00);
        end
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        tick();

        merge_b = 32'h1122_3344;
        mem[mkey(0, 32'h40)] = 32'hAABB_CCDD;
        store(0, 2'b00, 32'h40, 1'b0);
        chk("byte_written", last_written, 32'hAABB_CC44);
        mem[mkey(0, 32'h40)] = 32'hAABB_CCDD;
        store(0, 2'b01, 32'h40, 1'b1);
        chk("half_written", last_written, 32'hAABB_3344);
        store(0, 2'b10, 32'h80, 1'b0);
        chk("word_written", last_written, 32'h1122_3344);
        chk("word_mdr_kept", mdr[0], 32'hAABB_CCDD);
        store(0, 2'b11, 32'h44, 1'b0);
        reset_mid(0, 32'h40);

        mem[mkey(1, 32'h40)] = 32'hAABB_CCDD;
        store(1, 2'b00, 32'h40, 1'b1);
        chk("lat3_byte_written", last_written, 32'hAABB_CC44);

        for (int i = 0; i < 60; i++) begin
            int d;
            d = int'($urandom_range(0, 1));
            merge_b = $urandom;
            if ($urandom_range(0, 15) == 0) begin
                reset_mid(d, 32'($urandom_range(0, 7)) << 2);
            end else begin
                store(d, 2'($urandom), 32'($urandom_range(0, 7)) << 2,
                      1'($urandom_range(0, 1)));
            end
        end

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule

// File: doc/store_rmw_sequencer.md
Name: store_rmw_sequencer

Overview:
- Multicycle sequencer placed directly upstream of the store-size merge stage.
- Sub-word stores (byte or halfword) go through a read-modify-write. The sequencer first reads the target memory word and holds it in an internal memory-data register. That register feeds the merge stage's memory-word input, while the merge stage's size control is driven from here.
- Once the merged word is stable, the sequencer issues the memory write. Word stores skip the read.

Parameters:
- MEM_LATENCY, 1, cycles between presenting a read address (mem_wr=0) and valid mem_rdata. Legal range 1..15.
- ADDR_W, 32, memory address width.

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a store. Sampled only in IDLE.
- size_ctrl  input  2  store size: 00 byte, 01 halfword, 10 word, 11 illegal.
- addr_in  input  ADDR_W  target word address, latched with start.
- mem_rdata  input  32  memory read data.
- mem_addr  output  ADDR_W  address presented to memory.
- mem_wr  output  1  memory write enable, 1 = write the merge-stage result.
- mdr_out  output  32  captured memory word, feeds the merge-stage data input.
- store_size_out  output  2  latched size, feeds the merge-stage size control.
- busy  output  1  high while a store is in progress.
- done  output  1  one-cycle pulse when the store completes.
- size_err  output  1  one-cycle pulse when start arrives with size_ctrl=11.

Behaviour:
- Reset: state=IDLE, mem_addr=0, mem_wr=0, mdr_out=0, store_size_out=00, busy=0, done=0, size_err=0, latency counter=0.
- Reset is sampled every edge and has priority over all other inputs. Asserting it mid-operation returns the block to IDLE on that edge with the reset values above. No write may occur in the cycle following reset.
- Cycle numbering: start is sampled high at edge E0; cycle k is the period after edge Ek.
- States: IDLE, RD_WAIT, WRITE, DONE.
- IDLE: busy=0, mem_wr=0. On start=1:
  - size_ctrl 00 or 01: latch addr_in into mem_addr and size_ctrl into store_size_out, load counter with MEM_LATENCY, go to RD_WAIT.
  - size_ctrl 10: latch address and size, go directly to WRITE. mdr_out is unchanged.
  - size_ctrl 11: size_err=1 in cycle 1, stay in IDLE, latched registers unchanged.
- RD_WAIT: busy=1, mem_wr=0, mem_addr held.
  - Counter decrements every edge.
  - On the edge where the counter goes 1->0, mdr_out captures mem_rdata and the state goes to WRITE.
  - Occupies cycles 1..MEM_LATENCY.
- WRITE: busy=1, mem_wr=1 for exactly one cycle, mem_addr and store_size_out held. Then go to DONE.
  - Sub-word store: WRITE is cycle MEM_LATENCY+1.
  - Word store: WRITE is cycle 1.
- DONE: busy=1, done=1 for one cycle, mem_wr=0, then go to IDLE. A start sampled at the DONE->IDLE edge is ignored; the earliest accepted start is in the first IDLE cycle.
- start is ignored whenever state is not IDLE. No queuing.
- Once a store is accepted, mdr_out, store_size_out and mem_addr are stable from the start of WRITE until the next accepted start.
- mem_wr is never high in any state other than WRITE.
- Total latency, start to done:
  - Sub-word: MEM_LATENCY+2 cycles.
  - Word: 2 cycles.
- Counter is 4 bits. MEM_LATENCY=0 or >15 is a configuration error; flag it with an elaboration-time check.

Test Plan:
- Byte store, MEM_LATENCY=1. Memory model: mem[0x40]=0xAABBCCDD; merge stage: B=0x11223344. start with size_ctrl=00, addr 0x40 -> RD_WAIT in cycle 1; mdr_out=0xAABBCCDD and mem_wr=1 with mem_addr=0x40 and store_size_out=00 in cycle 2; word written is 0xAABBCC44; done in cycle 3.
- Halfword store, same setup, size_ctrl=01 -> written 0xAABB3344, done in cycle 3, single mem_wr pulse.
- Word store, size_ctrl=10, addr 0x80, previous mdr_out=0xAABBCCDD -> mem_wr in cycle 1 with no read phase; written 0x11223344; mdr_out stays 0xAABBCCDD; done in cycle 2.
- Illegal size, size_ctrl=11 -> size_err=1 in cycle 1 only; busy and mem_wr stay 0; mem_addr and store_size_out unchanged.
- Protocol and reset: start re-asserted during RD_WAIT and DONE is ignored (one write only). Separately, reset asserted in cycle 1 of a byte store -> cycle 2 shows IDLE, mdr_out=0, busy=0, and mem_wr never goes high.
- MEM_LATENCY=3, byte store -> RD_WAIT in cycles 1..3; mdr_out captures the mem_rdata present in cycle 3; mem_wr in cycle 4; done in cycle 5.
